// File: rtl/uart_tx_frame_engine_if.sv
// Host-side bundle for the UART TX frame engine: oversample tick, abort, payload handshake and line status.
// Master = host/FIFO side, slave = engine side.
interface uart_tx_frame_engine_if #(
    parameter int DATA_BITS = 8
);
    logic                 UART_CE;
    logic                 TXCT_R;
    logic [DATA_BITS-1:0] TX_DATA;
    logic                 TX_VALID;
    logic                 TX_READY;
    logic                 TX;
    logic                 TX_BUSY;
    logic                 TX_CE;
    logic                 TX_DONE;

    modport master (
        output UART_CE, TXCT_R, TX_DATA, TX_VALID,
        input  TX_READY, TX, TX_BUSY, TX_CE, TX_DONE
    );

    modport slave (
        input  UART_CE, TXCT_R, TX_DATA, TX_VALID,
        output TX_READY, TX, TX_BUSY, TX_CE, TX_DONE
    );
endinterface

// File: rtl/uart_tx_frame_engine.sv
// UART TX frame engine: start, DATA_BITS (LSB first), optional parity (UART_TX_PARITY_EN), STOP_BITS stop bits.
// Latency: TX goes low the edge after accept; each bit lasts OVERSAMPLE UART_CE ticks; TX_DONE pulses after the last stop bit.
// Backpressure: TX_READY only in IDLE without abort; TX_VALID is ignored for the rest of the frame.
module uart_tx_frame_engine #(
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8,
    parameter int STOP_BITS  = 1,
    parameter int PARITY_ODD = 0
) (
    input  logic                   CLK,
    input  logic                   RST_N,
    uart_tx_frame_engine_if.slave  bus
);
    localparam int CW = $clog2(OVERSAMPLE);
    localparam int IW = $clog2(DATA_BITS);
    localparam logic [CW-1:0] CNT_MAX = CW'(OVERSAMPLE - 1);
    localparam logic [IW-1:0] IDX_MAX = IW'(DATA_BITS - 1);
    localparam logic STOP_LAST = (STOP_BITS == 2);

    if (OVERSAMPLE < 2 || OVERSAMPLE > 256) begin : g_bad_oversample
        $error("OVERSAMPLE must be 2..256");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
        $error("DATA_BITS must be 5..9");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
        $error("STOP_BITS must be 1 or 2");
    end
    if (PARITY_ODD != 0 && PARITY_ODD != 1) begin : g_bad_parity_odd
        $error("PARITY_ODD must be 0 or 1");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_TX_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [IW-1:0]        idx_q, idx_d;
    logic                 stop_q, stop_d;
    logic [DATA_BITS-1:0] sh_q, sh_d;
    logic                 tx_q, tx_d;
    logic                 done_q, done_d;
    logic                 tx_ce;
    logic                 tx_ready;
`ifdef UART_TX_PARITY_EN
    logic                 par_q, par_d;
`endif

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            stop_q  <= 1'b0;
            sh_q    <= '0;
            tx_q    <= 1'b1;
            done_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            stop_q  <= stop_d;
            sh_q    <= sh_d;
            tx_q    <= tx_d;
            done_q  <= done_d;
`ifdef UART_TX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    always_comb begin
        tx_ce    = bus.UART_CE && (cnt_q == CNT_MAX) && (state_q != S_IDLE);
        tx_ready = (state_q == S_IDLE) && !bus.TXCT_R;
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        stop_d   = stop_q;
        sh_d     = sh_q;
        tx_d     = tx_q;
        done_d   = 1'b0;
`ifdef UART_TX_PARITY_EN
        par_d    = par_q;
`endif

        // Modulo-OVERSAMPLE tick counter; parked at 0 while idle.
        if (state_q != S_IDLE && bus.UART_CE) begin
            cnt_d = (cnt_q == CNT_MAX) ? '0 : cnt_q + 1'b1;
        end

        if (bus.TXCT_R) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            idx_d   = '0;
            stop_d  = 1'b0;
            sh_d    = '0;
            tx_d    = 1'b1;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.TX_VALID) begin
                        state_d = S_START;
                        sh_d    = bus.TX_DATA;
                        cnt_d   = '0;
                        idx_d   = '0;
                        stop_d  = 1'b0;
                        tx_d    = 1'b0;
`ifdef UART_TX_PARITY_EN
                        par_d   = (^bus.TX_DATA) ^ 1'(PARITY_ODD != 0);
`endif
                    end
                end
                S_START: begin
                    if (tx_ce) begin
                        state_d = S_DATA;
                        idx_d   = '0;
                        tx_d    = sh_q[0];
                        sh_d    = sh_q >> 1;
                    end
                end
                S_DATA: begin
                    if (tx_ce) begin
                        if (idx_q == IDX_MAX) begin
`ifdef UART_TX_PARITY_EN
                            state_d = S_PARITY;
                            tx_d    = par_q;
`else
                            state_d = S_STOP;
                            tx_d    = 1'b1;
`endif
                        end else begin
                            idx_d = idx_q + 1'b1;
                            tx_d  = sh_q[0];
                            sh_d  = sh_q >> 1;
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                S_PARITY: begin
                    if (tx_ce) begin
                        state_d = S_STOP;
                        tx_d    = 1'b1;
                    end
                end
`endif
                S_STOP: begin
                    if (tx_ce) begin
                        if (stop_q == STOP_LAST) begin
                            state_d = S_IDLE;
                            stop_d  = 1'b0;
                            done_d  = 1'b1;
                        end else begin
                            stop_d = 1'b1;
                        end
                        tx_d = 1'b1;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    tx_d    = 1'b1;
                end
            endcase
        end
    end

    assign bus.TX       = tx_q;
    assign bus.TX_BUSY  = (state_q != S_IDLE);
    assign bus.TX_CE    = tx_ce;
    assign bus.TX_DONE  = done_q;
    assign bus.TX_READY = tx_ready;
endmodule

// File: tb/tb_uart_tx_frame_engine.sv
// Bench for uart_tx_frame_engine: default instance (16x, 8N1) and a 5x, 2-stop, odd-parity instance.
module tb_uart_tx_frame_engine;
    logic CLK = 1'b0;
    logic RST_N;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   per_a = 1, per_b = 1, ph_a = 0, ph_b = 0;

    always #5 CLK = ~CLK;

    uart_tx_frame_engine_if #(.DATA_BITS(8)) ifa ();
    uart_tx_frame_engine_if #(.DATA_BITS(8)) ifb ();

    uart_tx_frame_engine dut_a (.CLK(CLK), .RST_N(RST_N), .bus(ifa));
    uart_tx_frame_engine #(.OVERSAMPLE(5), .DATA_BITS(8), .STOP_BITS(2), .PARITY_ODD(1))
        dut_b (.CLK(CLK), .RST_N(RST_N), .bus(ifb));

    // Oversample ticks, one CLK wide, every per_x CLKs; changed away from both edges.
    always @(posedge CLK) begin
        #2;
        ph_a = (ph_a + 1 >= per_a) ? 0 : ph_a + 1;
        ph_b = (ph_b + 1 >= per_b) ? 0 : ph_b + 1;
        ifa.UART_CE = (ph_a == 0);
        ifb.UART_CE = (ph_b == 0);
    end

    typedef struct {
        bit          sel;
        logic [7:0]  data;
        int          ce_per;
        int          nbits;
        logic [11:0] exp;
    } vec_t;

    vec_t tbl [6];

`ifdef UART_TX_PARITY_EN
    localparam int          NA  = 11;
    localparam logic [11:0] E00 = {1'b0, 1'b1, 1'b0, 8'h00, 1'b0};
    localparam logic [11:0] EFF = {1'b0, 1'b1, 1'b0, 8'hFF, 1'b0};
    localparam logic [11:0] E5A = {1'b0, 1'b1, 1'b0, 8'h5A, 1'b0};
`else
    localparam int          NA  = 10;
    localparam logic [11:0] E00 = {2'b00, 1'b1, 8'h00, 1'b0};
    localparam logic [11:0] EFF = {2'b00, 1'b1, 8'hFF, 1'b0};
    localparam logic [11:0] E5A = {2'b00, 1'b1, 8'h5A, 1'b0};
`endif

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic chk_rng(input string nm, input int act, input int lo, input int hi);
        n_checks++;
        if (act < lo || act > hi) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d..%0d", nm, act, lo, hi);
        end
    endtask

    task automatic smp(input bit sel, output logic tx, output logic ce, output logic dn,
                       output logic rdy, output logic bsy);
        if (sel) begin
            tx = ifb.TX; ce = ifb.TX_CE; dn = ifb.TX_DONE; rdy = ifb.TX_READY; bsy = ifb.TX_BUSY;
        end else begin
            tx = ifa.TX; ce = ifa.TX_CE; dn = ifa.TX_DONE; rdy = ifa.TX_READY; bsy = ifa.TX_BUSY;
        end
    endtask

    task automatic drv_valid(input bit sel, input logic v);
        if (sel) ifb.TX_VALID = v; else ifa.TX_VALID = v;
    endtask

    task automatic drv_data(input bit sel, input logic [7:0] d);
        if (sel) ifb.TX_DATA = d; else ifa.TX_DATA = d;
    endtask

    // Presents a payload at a negedge; the following posedge accepts it.
    task automatic send(input bit sel, input logic [7:0] d);
        logic tx, ce, dn, rdy, bsy;
        @(negedge CLK);
        drv_valid(sel, 1'b1);
        drv_data(sel, d);
        #1;
        smp(sel, tx, ce, dn, rdy, bsy);
        chk("accept_ready", rdy, 1);
    endtask

    // Follows one frame from the negedge after its accept edge up to the TX_DONE pulse.
    task automatic check_frame(input bit sel, input logic [11:0] exp, input int nbits,
                               input int bit_clks, input int ce_per, input bit drop,
                               input logic [7:0] nxt, input bit tail);
        logic tx, ce, dn, rdy, bsy;
        int   b = 0, len = 0, ndone = 0;
        bit   bad = 0, rdy_hi = 0, fin = 0;
        for (int c = 0; c < 5000 && !fin; c++) begin
            @(negedge CLK);
            if (c == 0) begin
                if (drop) drv_valid(sel, 1'b0);
                drv_data(sel, nxt);
            end
            #1;
            smp(sel, tx, ce, dn, rdy, bsy);
            if (dn) begin
                ndone++;
                fin = 1;
                chk("done_tx_high", tx, 1);
                chk("done_ready", rdy, 1);
            end else if (b < nbits) begin
                len++;
                if (tx !== exp[b]) bad = 1;
                if (rdy) rdy_hi = 1;
                if (ce) begin
                    chk($sformatf("bit%0d_value", b), bad, 0);
                    if (b == 0) chk_rng("start_bit_len", len, bit_clks - ce_per + 1, bit_clks);
                    else chk($sformatf("bit%0d_len", b), len, bit_clks);
                    b++;
                    len = 0;
                    bad = 0;
                end
            end
        end
        chk("tx_ce_per_frame", b, nbits);
        chk("tx_done_count", ndone, 1);
        chk("ready_low_in_frame", rdy_hi, 0);
        if (tail) begin
            @(negedge CLK);
            #1;
            smp(sel, tx, ce, dn, rdy, bsy);
            chk("done_one_clk", dn, 0);
            chk("idle_after_frame", bsy, 0);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic tx, ce, dn, rdy, bsy;
        int   nce;

`ifdef UART_TX_PARITY_EN
        tbl[0] = '{1'b0, 8'hA5, 4, 11, {1'b0, 1'b1, 1'b0, 8'hA5, 1'b0}};
        tbl[1] = '{1'b0, 8'h3C, 1, 11, {1'b0, 1'b1, 1'b0, 8'h3C, 1'b0}};
        tbl[2] = '{1'b0, 8'h00, 2, 11, {1'b0, 1'b1, 1'b0, 8'h00, 1'b0}};
        tbl[3] = '{1'b1, 8'h3C, 1, 12, {2'b11, 1'b1, 8'h3C, 1'b0}};
        tbl[4] = '{1'b1, 8'hA5, 3, 12, {2'b11, 1'b1, 8'hA5, 1'b0}};
        tbl[5] = '{1'b1, 8'h07, 2, 12, {2'b11, 1'b0, 8'h07, 1'b0}};
`else
        tbl[0] = '{1'b0, 8'hA5, 4, 10, {2'b00, 1'b1, 8'hA5, 1'b0}};
        tbl[1] = '{1'b0, 8'h3C, 1, 10, {2'b00, 1'b1, 8'h3C, 1'b0}};
        tbl[2] = '{1'b0, 8'h00, 2, 10, {2'b00, 1'b1, 8'h00, 1'b0}};
        tbl[3] = '{1'b1, 8'h3C, 1, 11, {1'b0, 2'b11, 8'h3C, 1'b0}};
        tbl[4] = '{1'b1, 8'hA5, 3, 11, {1'b0, 2'b11, 8'hA5, 1'b0}};
        tbl[5] = '{1'b1, 8'h07, 2, 11, {1'b0, 2'b11, 8'h07, 1'b0}};
`endif

        RST_N = 1'b0;
        ifa.TXCT_R = 1'b0; ifa.TX_VALID = 1'b0; ifa.TX_DATA = 8'h00;
        ifb.TXCT_R = 1'b0; ifb.TX_VALID = 1'b0; ifb.TX_DATA = 8'h00;

        // Reset state
        repeat (3) @(negedge CLK);
        #1;
        smp(1'b0, tx, ce, dn, rdy, bsy);
        chk("rst_tx", tx, 1);
        chk("rst_busy", bsy, 0);
        chk("rst_done", dn, 0);
        chk("rst_tx_ce", ce, 0);
        @(negedge CLK);
        RST_N = 1'b1;
        @(negedge CLK);
        #1;
        smp(1'b0, tx, ce, dn, rdy, bsy);
        chk("post_rst_ready_a", rdy, 1);
        chk("post_rst_tx_ce_a", ce, 0);
        smp(1'b1, tx, ce, dn, rdy, bsy);
        chk("post_rst_ready_b", rdy, 1);

        // Single frames, both instances, several tick rates
        for (int i = 0; i < 6; i++) begin
            if (tbl[i].sel) per_b = tbl[i].ce_per; else per_a = tbl[i].ce_per;
            repeat (2) @(negedge CLK);
            send(tbl[i].sel, tbl[i].data);
            check_frame(tbl[i].sel, tbl[i].exp, tbl[i].nbits,
                        (tbl[i].sel ? 5 : 16) * tbl[i].ce_per, tbl[i].ce_per,
                        1'b1, 8'($urandom), 1'b1);
        end

        // Back-to-back: TX_VALID held across two frames
        per_a = 1;
        send(1'b0, 8'h00);
        check_frame(1'b0, E00, NA, 16, 1, 1'b0, 8'hFF, 1'b0);
        smp(1'b0, tx, ce, dn, rdy, bsy);
        chk("b2b_gap_ready", rdy, 1);
        chk("b2b_gap_tx", tx, 1);
        check_frame(1'b0, EFF, NA, 16, 1, 1'b1, 8'h00, 1'b1);
        @(negedge CLK);
        #1;
        smp(1'b0, tx, ce, dn, rdy, bsy);
        chk("b2b_no_third_frame", bsy, 0);

        // Abort in the middle of data bit 3 with a new payload presented
        send(1'b0, 8'hA5);
        nce = 0;
        for (int c = 0; c < 200 && nce < 4; c++) begin
            @(negedge CLK);
            if (c == 0) drv_valid(1'b0, 1'b0);
            #1;
            smp(1'b0, tx, ce, dn, rdy, bsy);
            if (ce) nce++;
        end
        chk("abort_reach_bit3", nce, 4);
        repeat (8) @(negedge CLK);
        #1;
        smp(1'b0, tx, ce, dn, rdy, bsy);
        chk("abort_bit3_value", tx, 0);
        ifa.TXCT_R = 1'b1;
        ifa.TX_VALID = 1'b1;
        ifa.TX_DATA = 8'h5A;
        #1;
        smp(1'b0, tx, ce, dn, rdy, bsy);
        chk("abort_ready_low", rdy, 0);
        @(negedge CLK);
        #1;
        smp(1'b0, tx, ce, dn, rdy, bsy);
        chk("abort_tx_high", tx, 1);
        chk("abort_busy", bsy, 0);
        chk("abort_no_done", dn, 0);
        ifa.TXCT_R = 1'b0;
        #1;
        smp(1'b0, tx, ce, dn, rdy, bsy);
        chk("abort_not_accepted", rdy, 1);
        check_frame(1'b0, E5A, NA, 16, 1, 1'b1, 8'h00, 1'b1);

        // Asynchronous reset in the middle of a data bit
        send(1'b0, 8'h00);
        for (int c = 0; c < 30; c++) begin
            @(negedge CLK);
            if (c == 0) drv_valid(1'b0, 1'b0);
        end
        #1;
        smp(1'b0, tx, ce, dn, rdy, bsy);
        chk("pre_rst_tx_low", tx, 0);
        RST_N = 1'b0;
        #1;
        smp(1'b0, tx, ce, dn, rdy, bsy);
        chk("async_rst_tx", tx, 1);
        chk("async_rst_busy", bsy, 0);
        @(negedge CLK);
        RST_N = 1'b1;
        #1;
        smp(1'b0, tx, ce, dn, rdy, bsy);
        chk("rst_release_ready", rdy, 1);
        send(1'b0, 8'hFF);
        check_frame(1'b0, EFF, NA, 16, 1, 1'b1, 8'h00, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
